// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared constants, state encoding and accumulator type for the FC classifier
package fc_pkg;

    localparam int N_IN    = 16;
    localparam int N_CLASS = 10;
    localparam int ACT_W   = 4;
    localparam int W_W     = 4;
    localparam int ACC_W   = 12;
    localparam int PROD_W  = ACT_W + W_W + 1;

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MAC    = 2'd1,
        ST_ARGMAX = 2'd2,
        ST_DONE   = 2'd3
    } fc_state_t;

endpackage

// File: rtl/fc_mac_lane.sv
// rtl/fc_mac_lane.sv - one signed multiply-accumulate lane with load and enable
module fc_mac_lane
    import fc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [ACC_W-1:0] load_val,
    input  logic             en,
    input  logic [ACT_W-1:0] act,
    input  logic [W_W-1:0]   wgt,
    output logic [ACC_W-1:0] acc
);

    logic signed [PROD_W-1:0] act_x;
    logic signed [PROD_W-1:0] wgt_x;
    logic signed [PROD_W-1:0] prod;
    acc_t                     prod_ext;
    acc_t                     acc_q;

    // Activation is unsigned (zero-extended); weight is two's complement.
    assign act_x    = PROD_W'($signed({1'b0, act}));
    assign wgt_x    = PROD_W'($signed(wgt));
    assign prod     = act_x * wgt_x;
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (load) begin
            acc_q <= acc_t'(load_val);
        end else if (en) begin
            acc_q <= acc_q + prod_ext;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fc_classifier_16.sv
// rtl/fc_classifier_16.sv - 16-input FC classifier: parallel MAC lanes then sequential argmax; FC_BIAS_EN adds a bias port
module fc_classifier_16
    import fc_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_flag,
    input  logic [N_IN*ACT_W-1:0]        in,
    input  logic [N_CLASS*N_IN*W_W-1:0]  weight,
`ifdef FC_BIAS_EN
    input  logic [N_CLASS*ACC_W-1:0]     bias,
`endif
    output logic [N_CLASS*ACC_W-1:0]     scores,
    output logic [3:0]                   class_id,
    output logic                         busy,
    output logic                         end_flag
);

    localparam logic [3:0] E_LAST = 4'(N_IN - 1);
    localparam logic [3:0] K_LAST = 4'(N_CLASS - 1);

    fc_state_t state, state_next;

    logic [N_IN*ACT_W-1:0]       in_r;
    logic [N_CLASS*N_IN*W_W-1:0] weight_r;
    logic [3:0]                  e_cnt;
    logic [3:0]                  k_cnt;
    acc_t                        best;
    logic [3:0]                  class_q;

    logic                        accept;
    logic                        mac_en;

    logic [ACT_W-1:0]            act_arr [N_IN];
    logic [W_W-1:0]              w_arr   [N_CLASS][N_IN];
    acc_t                        acc     [N_CLASS];
    logic [ACT_W-1:0]            cur_act;
    acc_t                        acc_k;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mac_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_flag) begin
                    accept     = 1'b1;
                    state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (e_cnt == E_LAST) begin
                    state_next = ST_ARGMAX;
                end
            end
            ST_ARGMAX: begin
                if (k_cnt == K_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_r     <= '0;
            weight_r <= '0;
            e_cnt    <= '0;
            k_cnt    <= '0;
            best     <= '0;
            class_q  <= '0;
        end else begin
            if (accept) begin
                in_r     <= in;
                weight_r <= weight;
                e_cnt    <= '0;
            end
            if (mac_en) begin
                e_cnt <= e_cnt + 4'd1;
                k_cnt <= '0;
            end
            if (state == ST_ARGMAX) begin
                k_cnt <= (k_cnt == K_LAST) ? 4'd0 : k_cnt + 4'd1;
                // Strict compare keeps the earliest index on ties.
                if (k_cnt == 4'd0) begin
                    best    <= acc_k;
                    class_q <= 4'd0;
                end else if (acc_k > best) begin
                    best    <= acc_k;
                    class_q <= k_cnt;
                end
            end
        end
    end

    always_comb begin
        for (int e = 0; e < N_IN; e++) begin
            act_arr[e] = in_r[e*ACT_W +: ACT_W];
        end
        for (int c = 0; c < N_CLASS; c++) begin
            for (int e = 0; e < N_IN; e++) begin
                w_arr[c][e] = weight_r[(c*N_IN + e)*W_W +: W_W];
            end
        end
    end

    assign cur_act = act_arr[e_cnt];
    assign acc_k   = acc[k_cnt];

    for (genvar c = 0; c < N_CLASS; c++) begin : g_lane
        logic [ACC_W-1:0] load_val;
        logic [ACC_W-1:0] lane_acc;

`ifdef FC_BIAS_EN
        assign load_val = bias[c*ACC_W +: ACC_W];
`else
        assign load_val = '0;
`endif

        fc_mac_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .load     (accept),
            .load_val (load_val),
            .en       (mac_en),
            .act      (cur_act),
            .wgt      (w_arr[c][e_cnt]),
            .acc      (lane_acc)
        );

        assign acc[c]                    = acc_t'(lane_acc);
        assign scores[c*ACC_W +: ACC_W] = lane_acc;
    end

    assign class_id = class_q;
    assign busy     = (state != ST_IDLE);
    assign end_flag = (state == ST_DONE);

endmodule

// File: tb/tb_fc_classifier_16.sv
// tb/tb_fc_classifier_16.sv - directed table-driven bench for fc_classifier_16
module tb_fc_classifier_16;
    import fc_pkg::*;

    localparam int IN_BITS = N_IN * ACT_W;
    localparam int WB      = N_CLASS * N_IN * W_W;
    localparam int SB      = N_CLASS * ACC_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_flag;
    logic [IN_BITS-1:0] in_sig;
    logic [WB-1:0] weight;
    logic [SB-1:0] scores;
    logic [3:0]    class_id;
    logic          busy;
    logic          end_flag;
`ifdef FC_BIAS_EN
    logic [SB-1:0] bias;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fc_classifier_16 dut (
        .clk        (clk),
        .reset      (reset),
        .start_flag (start_flag),
        .in         (in_sig),
        .weight     (weight),
`ifdef FC_BIAS_EN
        .bias       (bias),
`endif
        .scores     (scores),
        .class_id   (class_id),
        .busy       (busy),
        .end_flag   (end_flag)
    );

    typedef struct {
        string              name;
        logic [IN_BITS-1:0] act;
        logic [WB-1:0]      w;
        logic [SB-1:0]      exp_s;
        logic [3:0]         exp_c;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Launches one run; optionally re-pulses start mid-run and/or in the DONE cycle.
    task automatic run_vec(input vec_t v, input int restart_at, input bit start_in_done);
        int cyc;
        int extra;
        @(negedge clk);
        start_flag = 1'b1;
        in_sig     = v.act;
        weight     = v.w;
        @(negedge clk);
        start_flag = 1'b0;
        cyc = 0;
        while (!end_flag && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start_flag = (cyc == restart_at);
            if (cyc == restart_at) in_sig = {N_IN{4'hF}};
        end
        start_flag = 1'b0;
        check({v.name, " latency"}, 128'(cyc), 128'd26);
        check({v.name, " scores"}, 128'(scores), 128'(v.exp_s));
        check({v.name, " class_id"}, 128'(class_id), 128'(v.exp_c));
        check({v.name, " busy_done"}, 128'(busy), 128'd1);
        if (start_in_done) start_flag = 1'b1;
        @(negedge clk);
        start_flag = 1'b0;
        check({v.name, " end_drop"}, 128'({busy, end_flag}), 128'd0);
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (end_flag) extra++;
        end
        check({v.name, " no_extra_end"}, 128'(extra), 128'd0);
        check({v.name, " scores_hold"}, 128'(scores), 128'(v.exp_s));
    endtask

    initial begin
        int ends;
        logic [SB-1:0] exp_tmp;

        vecs[0].name = "ramp_w";
        vecs[0].act  = {N_IN{4'h1}};
        vecs[0].w    = '0;
        vecs[0].exp_s = '0;
        for (int c = 0; c < N_CLASS; c++) begin
            for (int e = 0; e < N_IN; e++) vecs[0].w[(c*N_IN+e)*W_W +: W_W] = 4'(c - 5);
            vecs[0].exp_s[c*ACC_W +: ACC_W] = 12'(16 * (c - 5));
        end
        vecs[0].exp_c = 4'd9;

        vecs[1].name  = "all_min";
        vecs[1].act   = {N_IN{4'hF}};
        vecs[1].w     = {(N_CLASS*N_IN){4'h8}};
        vecs[1].exp_s = {N_CLASS{12'h880}};
        vecs[1].exp_c = 4'd0;

        vecs[2].name  = "single";
        vecs[2].act   = '0;
        vecs[2].act[7*ACT_W +: ACT_W] = 4'hF;
        vecs[2].w     = '0;
        vecs[2].w[(3*N_IN+7)*W_W +: W_W] = 4'd7;
        vecs[2].exp_s = '0;
        vecs[2].exp_s[3*ACC_W +: ACC_W] = 12'd105;
        vecs[2].exp_c = 4'd3;

        vecs[3].name  = "tie_2_8";
        vecs[3].act   = {N_IN{4'h2}};
        vecs[3].w     = '0;
        vecs[3].exp_s = '0;
        for (int e = 0; e < N_IN; e++) begin
            vecs[3].w[(2*N_IN+e)*W_W +: W_W] = 4'd7;
            vecs[3].w[(8*N_IN+e)*W_W +: W_W] = 4'd7;
        end
        vecs[3].exp_s[2*ACC_W +: ACC_W] = 12'd224;
        vecs[3].exp_s[8*ACC_W +: ACC_W] = 12'd224;
        vecs[3].exp_c = 4'd2;

        reset      = 1'b1;
        start_flag = 1'b0;
        in_sig     = '0;
        weight     = '0;
`ifdef FC_BIAS_EN
        bias       = '0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset scores", 128'(scores), 128'd0);
        check("reset class_id", 128'(class_id), 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset end_flag", 128'(end_flag), 128'd0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], 0, 1'b0);

        // Restart pulse at cycle 5 must be ignored; start in DONE also ignored.
        run_vec(vecs[0], 5, 1'b1);

        // Reset mid-run.
        @(negedge clk);
        start_flag = 1'b1;
        in_sig     = vecs[2].act;
        weight     = vecs[2].w;
        @(negedge clk);
        start_flag = 1'b0;
        repeat (9) @(negedge clk);
        check("midrun busy", 128'(busy), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst busy", 128'(busy), 128'd0);
        check("rst scores", 128'(scores), 128'd0);
        check("rst class_id", 128'(class_id), 128'd0);
        ends = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (end_flag) ends++;
        end
        check("rst no_end", 128'(ends), 128'd0);
        run_vec(vecs[1], 0, 1'b0);

`ifdef FC_BIAS_EN
        exp_tmp = '0;
        for (int c = 0; c < N_CLASS; c++) exp_tmp[c*ACC_W +: ACC_W] = 12'(c - 3);
        exp_tmp[4*ACC_W +: ACC_W] = 12'd100;
        bias = exp_tmp;
        begin
            vec_t vb;
            vb.name  = "bias";
            vb.act   = {N_IN{4'h5}};
            vb.w     = '0;
            vb.exp_s = exp_tmp;
            vb.exp_c = 4'd4;
            run_vec(vb, 0, 1'b0);
        end
`else
        exp_tmp = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
